ysyx_22040931_inst_fetch: RTL
=============================

# ysyx_22040931_inst_fetch

Instruction-fetch responder for the PC stage. It accepts a PC over the `pc_valid`/`if_ready` handshake, issues a single-beat read to instruction memory, and captures the returned word. It presents the {pc, inst} pair to the decode stage over a valid/ready handshake. It sits between the PC generator and ID, and discards in-flight fetches on pipeline flush.

## Interface
Parameters:
- PC_W, 64, PC / memory address width
- INST_W, 32, instruction width

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- flush  in  1  pipeline flush (branch/exception redirect); level, sampled each cycle
- pc_valid  in  1  PC stage offers a PC
- pc  in  PC_W  offered PC
- if_ready  out  1  block can accept a PC this cycle
- mem_req_valid  out  1  read request to instruction memory
- mem_req_addr  out  PC_W  request address, = latched PC
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  read data returned (always accepted; no resp ready)
- mem_resp_data  in  INST_W  returned instruction
- id_valid  out  1  {id_pc, id_inst} valid to decode
- id_ready  in  1  decode accepts
- id_pc  out  PC_W  PC of presented instruction
- id_inst  out  INST_W  presented instruction

## Operation
- Accept event: `acc = pc_valid & if_ready & ~flush`. On `acc`, latch `pc` into `pc_r`.
- `if_ready = (state==IDLE) | (state==HOLD & id_ready)`, combinational.
- States:
  - IDLE: outputs idle. `acc` -> REQ.
  - REQ: `mem_req_valid=1`, `mem_req_addr=pc_r`, held stable until the handshake.
    - `mem_req_ready & ~flush` -> WAIT.
    - `mem_req_ready & flush` -> DRAIN.
    - `~mem_req_ready & flush` -> IDLE (request withdrawn).
  - WAIT: `mem_resp_valid & ~flush` -> latch `inst_r=mem_resp_data`, go to HOLD. `flush` without resp -> DRAIN. `flush` with resp in the same cycle -> response dropped, go to IDLE.
  - DRAIN: `if_ready=0`, `id_valid=0`. `mem_resp_valid` -> data discarded, go to IDLE. Further flushes have no effect.
  - HOLD: `id_valid=1`, `id_pc=pc_r`, `id_inst=inst_r`.
    - `flush` -> IDLE; presentation dropped, `acc` blocked.
    - `id_ready & acc` -> REQ with new `pc_r` (back-to-back).
    - `id_ready & ~acc` -> IDLE.
    - `~id_ready` -> hold all outputs stable.
- At most one outstanding memory request. A response arriving in IDLE, REQ or HOLD is a protocol error: ignore it, and the bench flags it.
- No address alignment check; `pc` is passed through unmodified.
- `id_pc`/`id_inst` retain their last values when `id_valid=0`.

## Timing
- Reset (synchronous, checked at posedge): state=IDLE, `pc_r=0`, `inst_r=0`. In the first cycle after reset: `if_ready=1`, `mem_req_valid=0`, `id_valid=0`, `id_pc=0`, `id_inst=0`.
- Reset mid-operation (any state) returns to IDLE at that edge. Any later response from memory is ignored.
- Minimum latency, with `acc` in cycle T, `mem_req_ready=1` in T+1, and response in T+2:
  - `mem_req_valid` high in T+1.
  - `id_valid` high in T+3.
- Throughput with zero-wait memory and `id_ready=1`: one instruction per 3 cycles. HOLD->REQ chaining saves the IDLE cycle.
- `flush` takes effect in the same cycle: it blocks `acc`, and from the next edge `id_valid=0`.

## Test plan
- Basic fetch:
  - Stimulus: reset, then `pc_valid=1` with `pc=0x80000000` at T; `mem_req_ready=1` at T+1; resp `0x00000413` at T+2.
  - Required: `mem_req_addr=0x80000000` at T+1; `id_valid=1`, `id_pc=0x80000000`, `id_inst=0x00000413` at T+3.
- Back-pressure:
  - Stimulus: `mem_req_ready=0` for 3 cycles; then `id_ready=0` for 4 cycles after HOLD.
  - Required: `mem_req_valid`/`mem_req_addr` stable across the stall; `id_*` stable across the stall; `if_ready=0` throughout.
- Back-to-back:
  - Stimulus: in HOLD with `id_ready=1` and `pc_valid=1`, `pc=0x80000004`.
  - Required: same cycle `if_ready=1`; next cycle `mem_req_addr=0x80000004`, `id_valid=0`.
- Flush in WAIT:
  - Stimulus: flush one cycle after the request handshake; stale resp `0xDEADBEEF` 3 cycles later; then a new PC `0x80000100` with resp `0x00100073`.
  - Required: `if_ready=0` until the stale resp; `0xDEADBEEF` never appears on `id_inst`; `id_inst=0x00100073` presented with `id_pc=0x80000100`.
- Flush in REQ and HOLD:
  - Stimulus: flush while `mem_req_ready=0`; flush in HOLD with `id_ready=1` and `pc_valid=1`.
  - Required: for the REQ case, `mem_req_valid` drops next cycle and the block returns to IDLE. For the HOLD case, the PC is not accepted, `id_valid=0` next cycle, and the state is IDLE.
- Reset mid-operation:
  - Stimulus: assert reset in WAIT; after release, a late resp arrives.
  - Required: all outputs at reset values; `if_ready=1`; the late resp is ignored (`id_valid` stays 0).

Source files
------------

// File: rtl/ysyx_22040931_inst_fetch.sv
// Instruction-fetch responder: takes a PC, issues one memory read, presents {pc, inst} to decode.
// At most one read is outstanding; a flush either withdraws the request or drains the pending response.
module ysyx_22040931_inst_fetch #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              pc_valid,
    input  logic [PC_W-1:0]   pc,
    output logic              if_ready,
    output logic              mem_req_valid,
    output logic [PC_W-1:0]   mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [INST_W-1:0] mem_resp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst
);

    // state | meaning
    // IDLE  | no fetch in progress, ready for a PC
    // REQ   | read request offered to memory
    // WAIT  | request accepted, waiting for the response
    // DRAIN | flushed while a response is owed; discard it
    // HOLD  | instruction presented to decode
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     pc_r;
    logic [PC_W-1:0]     id_pc_r;
    logic [INST_W-1:0]   inst_r;
    logic                req_valid_r;
    logic                id_valid_r;
    logic                acc;

    assign if_ready = (state == IDLE) | ((state == HOLD) & id_ready);
    assign acc      = pc_valid & if_ready & ~flush;

    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = pc_r;
    assign id_valid      = id_valid_r;
    assign id_pc         = id_pc_r;
    assign id_inst       = inst_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc_r        <= '0;
            id_pc_r     <= '0;
            inst_r      <= '0;
            req_valid_r <= 1'b0;
            id_valid_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        state       <= REQ;
                        pc_r        <= pc;
                        req_valid_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state       <= flush ? DRAIN : WAIT;
                        req_valid_r <= 1'b0;
                    end else if (flush) begin
                        state       <= IDLE;
                        req_valid_r <= 1'b0;
                    end
                end
                WAIT: begin
                    // a response coinciding with the flush settles the debt, so no drain is needed
                    if (flush) begin
                        state <= mem_resp_valid ? IDLE : DRAIN;
                    end else if (mem_resp_valid) begin
                        state      <= HOLD;
                        inst_r     <= mem_resp_data;
                        id_pc_r    <= pc_r;
                        id_valid_r <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        state      <= IDLE;
                        id_valid_r <= 1'b0;
                    end else if (id_ready) begin
                        id_valid_r <= 1'b0;
                        if (acc) begin
                            state       <= REQ;
                            pc_r        <= pc;
                            req_valid_r <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_valid_r <= 1'b0;
                    id_valid_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
